comparator_seq_ctrl: RTL and testbench

- Sequencer for the 32-lane 2-bit comparator array; drives its D_IN, D_EN, SWITCH, COMPARE_EN and COMPARE_MODE, and collects its D_OUT.
- Per job: streams LOAD_LEN words into the array, issues one SWITCH pulse, issues CMP_LEN compare strobes, and returns each array result on a valid/ready stream.
- A credit-limited result FIFO absorbs output backpressure.

---
 rtl/comparator_seq_ctrl_if.sv | 30 +++
 rtl/comparator_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_comparator_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_seq_ctrl_if.sv
// Bundle of the load stream, result stream and comparator-array pins for comparator_seq_ctrl.
// Valid/ready: a beat transfers on a rising clock edge where valid and ready are both high; data is stable while valid waits.
interface comparator_seq_ctrl_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] arr_d_in;
  logic              arr_d_en;
  logic              arr_switch;
  logic              arr_compare_en;
  logic              arr_compare_mode;
  logic [DATA_W-1:0] arr_d_out;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, arr_d_out, m_ready,
    output s_ready, arr_d_in, arr_d_en, arr_switch, arr_compare_en, arr_compare_mode,
    output m_data, m_valid
  );

  modport master (
    output s_data, s_valid, arr_d_out, m_ready,
    input  s_ready, arr_d_in, arr_d_en, arr_switch, arr_compare_en, arr_compare_mode,
    input  m_data, m_valid
  );
endinterface

// File: rtl/comparator_seq_ctrl.sv
// Job sequencer for the 32-lane comparator array: load words, switch, issue
// credit-limited compare strobes and return results through a small FIFO.
module comparator_seq_ctrl #(
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 8,
  parameter int CMP_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstl,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] load_len,
  input  logic [LEN_W-1:0] cmp_len,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg,
  comparator_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SWITCH  = 3'd2,
    S_COMPARE = 3'd3,
    S_DRAIN   = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  load_left;
  logic [LEN_W-1:0]  cmp_left;
  logic [DATA_W-1:0] d_in_q;
  logic              d_en_q;
  logic              switch_q;
  logic              cen_q;
  logic              cmode_q;
  logic              done_q;

  logic [CMP_LAT-1:0] pipe;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];

  logic [CW:0] used;
  logic        credit;
  logic        issue;
  logic        push;
  logic        pop;

  // Credit counts results already queued plus those still travelling through the array.
  assign used   = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit = used < (CW+1)'(FIFO_DEPTH);
  assign issue  = (state == S_COMPARE) && credit;
  assign push   = pipe[CMP_LAT-1];
  assign pop    = bus.m_valid && bus.m_ready;

  assign busy                 = (state != S_IDLE);
  assign done                 = done_q;
  assign state_dbg            = state;
  assign bus.s_ready          = (state == S_LOAD);
  assign bus.arr_d_in         = d_in_q;
  assign bus.arr_d_en         = d_en_q;
  assign bus.arr_switch       = switch_q;
  assign bus.arr_compare_en   = cen_q;
  assign bus.arr_compare_mode = cmode_q;
  assign bus.m_valid          = (fifo_count != '0);
  assign bus.m_data           = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      state     <= S_IDLE;
      load_left <= '0;
      cmp_left  <= '0;
      d_in_q    <= '0;
      d_en_q    <= 1'b0;
      switch_q  <= 1'b0;
      cen_q     <= 1'b0;
      cmode_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      d_en_q   <= 1'b0;
      switch_q <= 1'b0;
      cen_q    <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          cmode_q   <= mode;
          load_left <= load_len;
          cmp_left  <= cmp_len;
          state     <= (load_len != '0) ? S_LOAD : S_SWITCH;
        end
        S_LOAD: if (bus.s_valid) begin
          d_in_q    <= bus.s_data;
          d_en_q    <= 1'b1;
          load_left <= load_left - LEN_W'(1);
          if (load_left == LEN_W'(1)) state <= S_SWITCH;
        end
        S_SWITCH: begin
          switch_q <= 1'b1;
          state    <= (cmp_left != '0) ? S_COMPARE : S_FINISH;
        end
        S_COMPARE: if (credit) begin
          cen_q    <= 1'b1;
          cmp_left <= cmp_left - LEN_W'(1);
          if (cmp_left == LEN_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: if (inflight == '0 && fifo_count == '0) state <= S_FINISH;
        S_FINISH: begin
          // DONE lands in the first IDLE cycle, together with BUSY falling.
          done_q  <= 1'b1;
          cmode_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      pipe     <= '0;
      inflight <= '0;
    end else begin
      pipe[0] <= cen_q;
      for (int i = 1; i < CMP_LAT; i++) pipe[i] <= pipe[i-1];
      case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstl) begin
    if (!rstl) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.arr_d_out;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Bench for comparator_seq_ctrl: directed jobs, array result model and an
// in-order scoreboard for loaded words and returned results.
module tb_comparator_seq_ctrl;
  localparam int DATA_W     = 64;
  localparam int LEN_W      = 8;
  localparam int CMP_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  logic             clk;
  logic             rstl;
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] load_len;
  logic [LEN_W-1:0] cmp_len;
  logic             busy;
  logic             done;
  logic [2:0]       state_dbg;

  comparator_seq_ctrl_if #(.DATA_W(DATA_W)) bus ();

  comparator_seq_ctrl #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .CMP_LAT(CMP_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstl(rstl), .start(start), .mode(mode),
    .load_len(load_len), .cmp_len(cmp_len),
    .busy(busy), .done(done), .state_dbg(state_dbg), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d_en_cnt = 0, sw_cnt = 0, cen_cnt = 0, m_cnt = 0, done_cnt = 0;
  int den_at_sw = 0, run = 0, max_run = 0, lost = 0, job_id = 0;
  logic job_mode = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] load_q[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] dout_f(input int n);
    logic [31:0] u;
    u = n;
    return {32'hC0DE_0000 ^ u, 32'h5A5A_5A5A + u};
  endfunction

  function automatic logic [DATA_W-1:0] word_f(input int j, input int i);
    logic [31:0] a, b;
    a = j;
    b = i;
    return {32'hBEEF_0000 | (a << 8) | b, ~(a * 32'h0101_0101 + b)};
  endfunction

  // array model and scoreboard monitor
  always @(negedge clk) begin
    bus.arr_d_out = dout_f(cyc);
    if (start && !busy) max_run = 0;
    if (bus.arr_d_en) begin
      d_en_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (load_q.size() == 0) chk("d_en_unexpected", 1, 0);
      else chk("arr_d_in", bus.arr_d_in, load_q.pop_front());
    end else begin
      run = 0;
    end
    if (bus.s_valid && bus.s_ready) load_q.push_back(bus.s_data);
    if (bus.arr_switch) begin
      sw_cnt++;
      den_at_sw = d_en_cnt;
    end
    if (bus.arr_compare_en) begin
      cen_cnt++;
      chk("compare_mode", bus.arr_compare_mode, job_mode);
      exp_q.push_back(dout_f(cyc + CMP_LAT));
      chk("credit_bound", (cen_cnt - m_cnt - lost) <= FIFO_DEPTH, 1);
    end
    if (bus.m_valid && bus.m_ready) begin
      m_cnt++;
      if (exp_q.size() == 0) chk("m_unexpected", 1, 0);
      else chk("m_data", bus.m_data, exp_q.pop_front());
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic send_beats(input int n, input bit gappy);
    int sent = 0;
    int k = 0;
    bit acc;
    while (sent < n && k < 200) begin
      bus.s_valid = gappy ? ((k % 2) == 0) : 1'b1;
      bus.s_data  = word_f(job_id, sent);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      k++;
    end
    bus.s_valid = 1'b0;
    chk("load_beats", sent, n);
  endtask

  task automatic run_job(input logic md, input int ll, input int cl, input bit gappy,
                         input int ready_delay, input bit inject);
    int den0, sw0, cen0, m0, done0, t0, t;
    bit injected = 0;
    bit raised = 0;
    job_id++;
    den0 = d_en_cnt; sw0 = sw_cnt; cen0 = cen_cnt; m0 = m_cnt; done0 = done_cnt;
    t0 = cyc;
    job_mode = md;
    bus.m_ready = (ready_delay == 0);
    mode = md;
    load_len = LEN_W'(ll);
    cmp_len = LEN_W'(cl);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_beats(ll, gappy);
    t = 0;
    while (done_cnt == done0 && t < 3000) begin
      if (cyc - t0 >= ready_delay) begin
        if (!raised && ready_delay > 0) chk("credit_limit", cen_cnt - cen0, FIFO_DEPTH);
        raised = 1;
        bus.m_ready = 1'b1;
      end
      if (inject && !injected && state_dbg == 3'd3) begin
        start = 1'b1;
        mode = ~md;
        load_len = 8'd5;
        cmp_len = 8'd5;
        injected = 1;
        chk("busy_in_compare", busy, 1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      t++;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - done0, 1);
    chk("d_en_count", d_en_cnt - den0, ll);
    chk("switch_count", sw_cnt - sw0, 1);
    chk("switch_after_load", den_at_sw - den0, ll);
    chk("compare_count", cen_cnt - cen0, cl);
    chk("m_beats", m_cnt - m0, cl);
    chk("d_en_run", max_run, gappy ? (ll > 0 ? 1 : 0) : ll);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
    chk("mode_idle", bus.arr_compare_mode, 0);
    chk("m_valid_idle", bus.m_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, state_dbg, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_d_in"}, bus.arr_d_in, 0);
    chk({tag, "_d_en"}, bus.arr_d_en, 0);
    chk({tag, "_switch"}, bus.arr_switch, 0);
    chk({tag, "_cen"}, bus.arr_compare_en, 0);
    chk({tag, "_cmode"}, bus.arr_compare_mode, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
  endtask

  initial begin
    int c0, d0, m0, t;
    rstl = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    load_len = '0;
    cmp_len = '0;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    bus.arr_d_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstl = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset");

    run_job(1'b1, 3, 2, 1'b0, 0, 1'b0);   // basic
    run_job(1'b0, 3, 2, 1'b1, 0, 1'b0);   // gappy load
    run_job(1'b1, 1, 10, 1'b0, 30, 1'b0); // backpressure
    run_job(1'b0, 0, 0, 1'b0, 0, 1'b0);   // zero lengths
    run_job(1'b1, 0, 1, 1'b0, 0, 1'b0);
    run_job(1'b1, 2, 6, 1'b0, 0, 1'b1);   // START ignored

    // reset with two results in flight
    job_id++;
    job_mode = 1'b1;
    bus.m_ready = 1'b0;
    mode = 1'b1;
    load_len = 8'd0;
    cmp_len = 8'd4;
    c0 = cen_cnt;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (cen_cnt - c0 < 2 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("reset_setup", cen_cnt - c0, 2);
    rstl = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    lost += cen_cnt - m_cnt - lost;
    m0 = m_cnt;
    repeat (3) @(negedge clk);
    rstl = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("after_reset_m_valid", bus.m_valid, 0);
    chk("after_reset_state", state_dbg, 0);
    chk("after_reset_no_done", done_cnt, d0);
    chk("after_reset_no_beats", m_cnt, m0);
    run_job(1'b0, 2, 3, 1'b0, 0, 1'b0);   // next job after reset

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
